dummy_accelerator_result_buffer: RTL and testbench
==================================================

DUMMY_ACCELERATOR_RESULT_BUFFER -- requirements
Module: dummy_accelerator_result_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, result data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of entries; a power of two, >= 2.
REQ-003 SHALL have parameter type TagType_t, default logic, the tag carried with each result (rd/id).
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port flush_i  input  1  discards all buffered entries.
REQ-007 SHALL have port valid_i  input  1  the upstream accelerator presents a result.
REQ-008 SHALL have port ready_o  output  1  the buffer accepts a result.
REQ-009 SHALL have port result_i  input  WIDTH  incoming result.
REQ-010 SHALL have port tag_i  input  TagType_t  incoming tag.
REQ-011 SHALL have port valid_o  output  1  a result is offered to writeback.
REQ-012 SHALL have port ready_i  input  1  writeback consumes the result.
REQ-013 SHALL have port result_o  output  WIDTH  oldest result.
REQ-014 SHALL have port tag_o  output  TagType_t  tag of the oldest result.
REQ-015 SHALL have port count_o  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-016 SHALL store entries as a circular FIFO with write pointer, read pointer and occupancy count; pointers wrap from DEPTH-1 to 0.
REQ-017 SHALL push when valid_i && ready_o, and pop when valid_o && ready_i; strict FIFO order, result and tag kept together.
REQ-018 SHALL drive ready_o = (count != DEPTH) && !flush_i; no combinational path from ready_i to ready_o.
REQ-019 SHALL drive valid_o = (count != 0) && !flush_i; result_o/tag_o come from the read-pointer entry.
REQ-020 SHALL hold count unchanged when a push and a pop occur in the same cycle, with both pointers advancing; this is legal at any occupancy 1..DEPTH-1.
REQ-021 SHALL give 1-cycle latency: an entry pushed in cycle N is offered no earlier than cycle N+1.
REQ-022 SHALL keep result_o/tag_o stable while valid_o && !ready_i.
REQ-023 SHALL, on flush_i, ignore push and pop in that cycle and zero both pointers and count at the next edge.
REQ-024 SHALL, at full (count == DEPTH), refuse pushes even if ready_i is high that cycle.
REQ-025 SHALL, at empty, pop nothing; ready_i is a don't-care.

Reset
REQ-026 SHALL, while rst_i is high at a clock edge, clear pointers and count to 0; reset has priority over flush_i.
REQ-027 SHALL, after reset, present ready_o=1, valid_o=0 and count_o=0; the storage array is not reset.
REQ-028 SHALL make reset mid-operation discard all entries, identical to flush.

Configuration
REQ-029 SHALL, with macro DUMMY_ACC_RESBUF_BYPASS_EN defined and count==0, drive valid_o=valid_i, result_o=result_i and tag_o=tag_i combinationally; on valid_i && ready_i the entry is not written.
REQ-030 SHALL, with DUMMY_ACC_RESBUF_BYPASS_EN defined and count==0 and valid_i && !ready_i, write the entry normally.
REQ-031 SHALL, without the macro, have no bypass path; REQ-021 latency applies always.
REQ-032 SHALL keep the bypass blocked by flush_i in both builds.

Structure
REQ-033 SHALL take the DEPTH default and the pointer/count width derivation from shared package dummy_accelerator_pkg.
REQ-034 SHALL put the storage array in sub-module dummy_accelerator_resbuf_mem, with a 1 write port, 1 asynchronous read port and no reset.

Verification
REQ-035 SHALL cover: reset, then push 0xA5 tag 1 with ready_i=0 -> valid_o=1 next cycle, result_o=0xA5, count_o=1.
REQ-036 SHALL cover: push 4 entries (0x1..0x4) with ready_i=0 -> ready_o=0, count_o=4; raise ready_i -> outputs 0x1,0x2,0x3,0x4 in order.
REQ-037 SHALL cover: at count 2, push and pop every cycle for 8 cycles -> count_o stays 2, pointers wrap, order preserved.
REQ-038 SHALL cover: at count 3, assert flush_i with valid_i=1 -> no push, next cycle count_o=0, valid_o=0, ready_o=1.
REQ-039 SHALL cover: with DUMMY_ACC_RESBUF_BYPASS_EN, empty buffer, valid_i=ready_i=1, result 0x5A -> result_o=0x5A same cycle, count_o stays 0; without the macro, 0x5A appears the next cycle.
REQ-040 SHALL cover: at full, assert rst_i together with flush_i -> count_o=0 next cycle.

Source files
------------

// File: rtl/dummy_accelerator_result_buffer_pkg.sv
// Shared constants, helpers and types for the accelerator result buffer.
// Optional feature macro used by this slice: DUMMY_ACC_RESBUF_BYPASS_EN.
package dummy_accelerator_pkg;

  localparam int unsigned DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Pointer width never drops below one bit so a degenerate depth still elaborates.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dummy_accelerator_result_buffer_if.sv
// Upstream (accelerator) and downstream (writeback) handshakes of the result buffer.
interface dummy_accelerator_result_buffer_if #(
  parameter int unsigned WIDTH = 32,
  parameter type TagType_t = logic
);

  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] result_i;
  TagType_t         tag_i;

  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;
  TagType_t         tag_o;

  modport slave (
    input  valid_i, result_i, tag_i, ready_i,
    output ready_o, valid_o, result_o, tag_o
  );

  modport master (
    output valid_i, result_i, tag_i, ready_i,
    input  ready_o, valid_o, result_o, tag_o
  );

endinterface

// File: rtl/dummy_accelerator_resbuf_mem.sv
// Result/tag storage: one synchronous write port, one asynchronous read port, no reset.
module dummy_accelerator_resbuf_mem
  import dummy_accelerator_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter type TagType_t = logic,
  localparam int unsigned PtrW = ptr_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we,
  input  logic [PtrW-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  TagType_t         wtag,
  input  logic [PtrW-1:0]  raddr,
  output logic [WIDTH-1:0] rdata,
  output TagType_t         rtag
);

  logic [WIDTH-1:0] result_mem [DEPTH];
  TagType_t         tag_mem    [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) begin
      result_mem[waddr] <= wdata;
      tag_mem[waddr]    <= wtag;
    end
  end

  assign rdata = result_mem[raddr];
  assign rtag  = tag_mem[raddr];

endmodule

// File: rtl/dummy_accelerator_result_buffer.sv
// Circular FIFO decoupling accelerator results from writeback.
// Define DUMMY_ACC_RESBUF_BYPASS_EN to forward results combinationally while empty.
module dummy_accelerator_result_buffer
  import dummy_accelerator_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter type TagType_t = logic,
  localparam int unsigned PtrW = ptr_width(DEPTH),
  localparam int unsigned CntW = count_width(DEPTH)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  dummy_accelerator_result_buffer_if.slave    bus,
  output logic [CntW-1:0]                     count_o
);

  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);
  localparam logic [PtrW-1:0] LastPtr   = PtrW'(DEPTH - 1);

  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             empty, full, bypass, push, pop;
  logic [WIDTH-1:0] mem_result;
  TagType_t         mem_tag;
  fifo_op_e         op;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + 1'b1;
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCount);

`ifdef DUMMY_ACC_RESBUF_BYPASS_EN
  assign bypass = empty && bus.valid_i && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  assign bus.ready_o  = !full && !flush_i;
  assign bus.valid_o  = (!empty || bypass) && !flush_i;
  assign bus.result_o = bypass ? bus.result_i : mem_result;
  assign bus.tag_o    = bypass ? bus.tag_i    : mem_tag;
  assign count_o      = count_q;

  // A bypassed result consumed in the same cycle never touches the storage.
  assign push = bus.valid_i && bus.ready_o && !(bypass && bus.ready_i);
  assign pop  = bus.valid_o && bus.ready_i && !empty;

  always_comb begin
    op = OP_NONE;
    if (push && pop) op = OP_BOTH;
    else if (push)   op = OP_PUSH;
    else if (pop)    op = OP_POP;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      unique case (op)
        OP_PUSH: begin
          wr_ptr_q <= next_ptr(wr_ptr_q);
          count_q  <= count_q + 1'b1;
        end
        OP_POP: begin
          rd_ptr_q <= next_ptr(rd_ptr_q);
          count_q  <= count_q - 1'b1;
        end
        OP_BOTH: begin
          wr_ptr_q <= next_ptr(wr_ptr_q);
          rd_ptr_q <= next_ptr(rd_ptr_q);
        end
        default: ;
      endcase
    end
  end

  dummy_accelerator_resbuf_mem #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .TagType_t (TagType_t)
  ) u_mem (
    .clk_i (clk_i),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (bus.result_i),
    .wtag  (bus.tag_i),
    .raddr (rd_ptr_q),
    .rdata (mem_result),
    .rtag  (mem_tag)
  );

endmodule

// File: tb/tb_dummy_accelerator_result_buffer.sv
// Directed plus short random bench for the result buffer; a queue scoreboard holds expected entries.
module tb_dummy_accelerator_result_buffer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
`ifdef DUMMY_ACC_RESBUF_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  typedef logic [3:0] tag_t;
  typedef struct packed {
    logic [WIDTH-1:0] res;
    tag_t             tag;
  } entry_t;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            flush_i;
  logic [CntW-1:0] count_o;

  entry_t sb[$];
  int     vectors     = 0;
  int     miscompares = 0;

  dummy_accelerator_result_buffer_if #(.WIDTH(WIDTH), .TagType_t(tag_t)) bus ();

  dummy_accelerator_result_buffer #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .TagType_t (tag_t)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .bus     (bus.slave),
    .count_o (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Sampled at the falling edge; the model decides push/pop from its own occupancy.
  task automatic checkOutput();
    int     cnt;
    logic   bypassNow, expReady, expValid, expPush, expPop;
    entry_t head;
    entry_t incoming;
    cnt            = sb.size();
    incoming.res   = bus.result_i;
    incoming.tag   = bus.tag_i;
    bypassNow      = Bypass && (cnt == 0) && bus.valid_i && !flush_i;
    expReady       = (cnt != DEPTH) && !flush_i;
    expValid       = ((cnt != 0) || bypassNow) && !flush_i;
    compare("ready_o", 32'(bus.ready_o), 32'(expReady));
    compare("valid_o", 32'(bus.valid_o), 32'(expValid));
    compare("count_o", 32'(count_o), 32'(cnt));
    if (expValid) begin
      head = bypassNow ? incoming : sb[0];
      compare("result_o", bus.result_o, head.res);
      compare("tag_o", 32'(bus.tag_o), 32'(head.tag));
    end
    expPop  = expValid && bus.ready_i && !bypassNow;
    expPush = bus.valid_i && expReady && !(bypassNow && bus.ready_i);
    if (rst_i || flush_i) begin
      sb.delete();
    end else begin
      if (expPop) void'(sb.pop_front());
      if (expPush) sb.push_back(incoming);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic r, input logic [31:0] res,
                               input tag_t tag, input logic fl = 1'b0, input logic rs = 1'b0);
    bus.valid_i  = v;
    bus.ready_i  = r;
    bus.result_i = res;
    bus.tag_i    = tag;
    flush_i      = fl;
    rst_i        = rs;
    @(negedge clk_i);
    checkOutput();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    bus.valid_i  = 1'b0;
    bus.ready_i  = 1'b0;
    bus.result_i = '0;
    bus.tag_i    = '0;
    flush_i      = 1'b0;
    rst_i        = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    $display("[TB] reset state");
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0);

    $display("[TB] single push, one-cycle latency");
    applyStimulus(1'b1, 1'b0, 32'hA5, 4'h1);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0);
    applyStimulus(1'b0, 1'b1, 32'h0, 4'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0);

    $display("[TB] fill to full, refused push, drain in order");
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 1'b0, 32'(i), 4'(i));
    applyStimulus(1'b1, 1'b1, 32'h99, 4'h9);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 32'h0, 4'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0);

    $display("[TB] steady push+pop at occupancy two");
    applyStimulus(1'b1, 1'b0, 32'h10, 4'hA);
    applyStimulus(1'b1, 1'b0, 32'h11, 4'hB);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 32'h20 + 32'(i), 4'(i));
    applyStimulus(1'b0, 1'b1, 32'h0, 4'h0);
    applyStimulus(1'b0, 1'b1, 32'h0, 4'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0);

    $display("[TB] flush at occupancy three");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h30 + 32'(i), 4'(i + 3));
    applyStimulus(1'b1, 1'b1, 32'hBAD, 4'hF, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0);

    $display("[TB] empty buffer with valid and ready together");
    applyStimulus(1'b1, 1'b1, 32'h5A, 4'h2);
    applyStimulus(1'b0, 1'b1, 32'h0, 4'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0);

    $display("[TB] reset with flush at full");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h40 + 32'(i), 4'(i));
    applyStimulus(1'b1, 1'b1, 32'h77, 4'h7, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 1'b0, 32'h50, 4'h5);
    applyStimulus(1'b1, 1'b0, 32'h51, 4'h6);
    applyStimulus(1'b1, 1'b1, 32'h66, 4'h6, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0);

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                    4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
